display_mux_driver: RTL and testbench



---
 rtl/display_mux_driver.sv | 81 ++++++++
 tb/tb_display_mux_driver.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/display_mux_driver.sv
// Two-digit 7-segment multiplexer: latches a BCD tens/units pair on a load strobe
// and alternates both digits on one shared segment bus at a fixed refresh rate.
module display_mux_driver #(
  parameter int REFRESH_PERIOD     = 1000,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ten_count,
  input  logic [3:0] unit_count,
  output logic [6:0] segments,
  output logic       digit
);

  localparam int CNT_W = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_PERIOD - 1);

  logic [3:0]       r_tensQ;
  logic [3:0]       r_unitsQ;
  logic [CNT_W-1:0] r_refreshCnt;
  logic             r_digit;
  logic [6:0]       r_segments;

  logic             w_wrap;
  logic             w_digitNext;
  logic [3:0]       w_sel;
  logic             w_blank;
  logic [6:0]       w_segNext;

  assign segments = r_segments;
  assign digit    = r_digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tensQ  <= 4'd0;
      r_unitsQ <= 4'd0;
    end else if (load) begin
      r_tensQ  <= ten_count;
      r_unitsQ <= unit_count;
    end
  end

  // Decode uses the digit being registered this edge so digit and segments never disagree.
  always_comb begin
    w_wrap      = (r_refreshCnt == CNT_MAX);
    w_digitNext = w_wrap ? ~r_digit : r_digit;
    w_sel       = w_digitNext ? r_tensQ : r_unitsQ;
    w_blank     = BLANK_LEADING_ZERO && w_digitNext && (r_tensQ == 4'd0);
    w_segNext   = 7'h40;
    case (w_sel)
      4'd0:    w_segNext = 7'h3F;
      4'd1:    w_segNext = 7'h06;
      4'd2:    w_segNext = 7'h5B;
      4'd3:    w_segNext = 7'h4F;
      4'd4:    w_segNext = 7'h66;
      4'd5:    w_segNext = 7'h6D;
      4'd6:    w_segNext = 7'h7D;
      4'd7:    w_segNext = 7'h07;
      4'd8:    w_segNext = 7'h7F;
      4'd9:    w_segNext = 7'h6F;
      default: w_segNext = 7'h40;
    endcase
    if (w_blank) begin
      w_segNext = 7'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_refreshCnt <= '0;
      r_digit      <= 1'b0;
      r_segments   <= 7'h00;
    end else begin
      r_refreshCnt <= w_wrap ? '0 : r_refreshCnt + CNT_W'(1);
      r_digit      <= w_digitNext;
      r_segments   <= w_segNext;
    end
  end

endmodule

// File: tb/tb_display_mux_driver.sv
// Scoreboard bench for display_mux_driver: a cycle-count reference model predicts each
// post-edge output pair for two instances (leading-zero blanking on and off).
module tb_display_mux_driver;

  localparam int P = 4;

  typedef struct {
    logic       dig;
    logic [6:0] segA;
    logic [6:0] segB;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] tenCount;
  logic [3:0] unitCount;
  logic [6:0] segA, segB;
  logic       digA, digB;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: non-reset edges since reset and the digits currently latched.
  int   mCyc   = 0;
  int   mTens  = 0;
  int   mUnits = 0;

  logic [6:0] decTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  display_mux_driver #(.REFRESH_PERIOD(P), .BLANK_LEADING_ZERO(1'b1)) dutA (
    .clk(clk), .reset(reset), .load(load), .ten_count(tenCount),
    .unit_count(unitCount), .segments(segA), .digit(digA)
  );

  display_mux_driver #(.REFRESH_PERIOD(P), .BLANK_LEADING_ZERO(1'b0)) dutB (
    .clk(clk), .reset(reset), .load(load), .ten_count(tenCount),
    .unit_count(unitCount), .segments(segB), .digit(digB)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] modelSeg(input bit tensPhase, input bit blank);
    if (tensPhase) return (blank && mTens == 0) ? 7'h00 : decTab[mTens];
    return decTab[mUnits];
  endfunction

  task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%h want=%h", name, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("digitA", {6'd0, digA}, {6'd0, e.dig});
      checkOutput("segA",   segA, e.segA);
      checkOutput("digitB", {6'd0, digB}, {6'd0, e.dig});
      checkOutput("segB",   segB, e.segB);
    end
  end

  // Digit phase after k edges is (k / P) mod 2; segments come from the digits latched before the edge.
  task automatic applyStimulus(input bit r, input bit l, input int t, input int u);
    exp_t e;
    bit   ph;
    reset     = r;
    load      = l;
    tenCount  = 4'(t);
    unitCount = 4'(u);
    if (r) begin
      mCyc = 0; mTens = 0; mUnits = 0;
      e = '{1'b0, 7'h00, 7'h00};
    end else begin
      mCyc++;
      ph = ((mCyc / P) % 2) == 1;
      e.dig  = ph;
      e.segA = modelSeg(ph, 1'b1);
      e.segB = modelSeg(ph, 1'b0);
      if (l) begin
        mTens = t; mUnits = u;
      end
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 7, 0);
    idle(9);

    applyStimulus(1'b0, 1'b1, 4, 2);
    idle(12);

    applyStimulus(1'b0, 1'b1, 0, 7);
    idle(10);

    applyStimulus(1'b0, 1'b1, 12, 15);
    idle(10);

    while (((mCyc + 1) % P) != 0) idle(1);
    applyStimulus(1'b0, 1'b1, 1, 9);
    idle(3);

    applyStimulus(1'b0, 1'b1, 3, 3);
    applyStimulus(1'b0, 1'b1, 2, 5);
    applyStimulus(1'b0, 1'b1, 6, 8);
    idle(9);

    applyStimulus(1'b0, 1'b1, 9, 3);
    while (((mCyc / P) % 2) == 0) idle(1);
    applyStimulus(1'b1, 1'b0, 0, 0);
    idle(10);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: pending=%0d want=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
